// File: rtl/v_alu_seq_pkg.sv
// Shared types and constants for the lane ALU sequencer.
package v_alu_seq_pkg;

    localparam int unsigned OPMODE_W = 9;
    localparam int unsigned SEW_W    = 3;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } v_alu_seq_state_e;

    localparam logic [OPMODE_W-1:0] OPM_ADD = 9'h001;
    localparam logic [OPMODE_W-1:0] OPM_SUB = 9'h002;
    localparam logic [OPMODE_W-1:0] OPM_MAC = 9'h040;

    localparam logic [SEW_W-1:0] SEW_8  = 3'b000;
    localparam logic [SEW_W-1:0] SEW_16 = 3'b001;
    localparam logic [SEW_W-1:0] SEW_32 = 3'b010;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } res_entry_t;

endpackage

// File: rtl/v_alu_res_fifo.sv
// Synchronous result FIFO; head entry is read straight from storage flops, no bypass.
module v_alu_res_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop in the same cycle frees the slot, so push is accepted even when full.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != OCC_W'(DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == OCC_W'(DEPTH));

endmodule

// File: rtl/v_alu_seq.sv
// Per-lane sequencer: issues vl element ops to the lane ALU and returns results under valid/ready.
module v_alu_seq
    import v_alu_seq_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                instr_vld_i,
    output logic                instr_rdy_o,
    input  logic [OPMODE_W-1:0] instr_opmode_i,
    input  logic [SEW_W-1:0]    instr_sew_i,
    input  logic [CNT_W-1:0]    instr_vl_i,
    input  logic                op_vld_i,
    output logic                op_rdy_o,
    input  logic [DATA_W-1:0]   op1_i,
    input  logic [DATA_W-1:0]   op2_i,
    input  logic [DATA_W-1:0]   op3_i,
    output logic [OPMODE_W-1:0] alu_opmode_o,
    output logic [SEW_W-1:0]    alu_sew_o,
    output logic [DATA_W-1:0]   alu_op1_o,
    output logic [DATA_W-1:0]   alu_op2_o,
    output logic [DATA_W-1:0]   alu_op3_o,
    output logic                alu_vld_o,
    input  logic                alu_vld_i,
    input  logic [DATA_W-1:0]   alu_result_i,
    output logic                res_vld_o,
    input  logic                res_rdy_i,
    output logic [DATA_W-1:0]   res_data_o,
    output logic                res_last_o,
    output logic                busy_o
);

    localparam int unsigned OUT_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = $bits(res_entry_t);

    if (FIFO_DEPTH < 1 || ALU_LATENCY < 1) begin : g_bad_params
        $error("v_alu_seq: FIFO_DEPTH and ALU_LATENCY must be at least 1");
    end

    v_alu_seq_state_e    state_q, state_d;
    logic [OPMODE_W-1:0] opmode_q, opmode_d;
    logic [SEW_W-1:0]    sew_q, sew_d;
    logic [CNT_W-1:0]    vl_q, vl_d;
    logic [OUT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [OUT_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic [OUT_W-1:0]    pop_cnt_q, pop_cnt_d;

    logic [OUT_W-1:0]    vl_ext;
    logic [OUT_W-1:0]    outstanding;
    logic                issue_fire, pop_fire;
    logic                fifo_empty, fifo_full;
    res_entry_t          push_entry, head_entry;

    // Next-state, counters and handshake outputs.
    always_comb begin
        state_d      = state_q;
        opmode_d     = opmode_q;
        sew_d        = sew_q;
        vl_d         = vl_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        pop_cnt_d    = pop_cnt_q;
        instr_rdy_o  = 1'b0;
        op_rdy_o     = 1'b0;
        issue_fire   = 1'b0;

        vl_ext      = {1'b0, vl_q};
        outstanding = issue_cnt_q - pop_cnt_q;
        res_vld_o   = !fifo_empty;
        pop_fire    = res_vld_o && res_rdy_i;

        if (alu_vld_i) begin
            ret_cnt_d = ret_cnt_q + OUT_W'(1);
        end
        if (pop_fire) begin
            pop_cnt_d = pop_cnt_q + OUT_W'(1);
        end

        case (state_q)
            IDLE: begin
                instr_rdy_o = 1'b1;
                if (instr_vld_i) begin
                    opmode_d    = instr_opmode_i;
                    sew_d       = instr_sew_i;
                    vl_d        = instr_vl_i;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    pop_cnt_d   = '0;
                    if (instr_vl_i != '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Credit check: every in-flight element already owns a FIFO slot.
                op_rdy_o   = (issue_cnt_q < vl_ext) &&
                             (outstanding < OUT_W'(FIFO_DEPTH)) && !fifo_full;
                issue_fire = op_vld_i && op_rdy_o;
                if (issue_fire) begin
                    issue_cnt_d = issue_cnt_q + OUT_W'(1);
                    if (issue_cnt_d == vl_ext) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_fire && (pop_cnt_d == vl_ext)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        alu_vld_o       = issue_fire;
        push_entry.data = alu_result_i;
        push_entry.last = (ret_cnt_q == vl_ext - OUT_W'(1));
        res_data_o      = head_entry.data;
        res_last_o      = res_vld_o && head_entry.last;
        busy_o          = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            opmode_q    <= '0;
            sew_q       <= '0;
            vl_q        <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            pop_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            opmode_q    <= opmode_d;
            sew_q       <= sew_d;
            vl_q        <= vl_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
        end
    end

    assign alu_opmode_o = opmode_q;
    assign alu_sew_o    = sew_q;
    assign alu_op1_o    = op1_i;
    assign alu_op2_o    = op2_i;
    assign alu_op3_o    = op3_i;

    v_alu_res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (alu_vld_i),
        .pop   (pop_fire),
        .din   (push_entry),
        .dout  (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_v_alu_seq.sv
// Directed bench for v_alu_seq with a behavioural fixed-latency ALU and a result scoreboard.
module tb_v_alu_seq;
    import v_alu_seq_pkg::*;

    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned CW    = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          instr_vld_i, instr_rdy_o;
    logic [8:0]    instr_opmode_i;
    logic [2:0]    instr_sew_i;
    logic [CW-1:0] instr_vl_i;
    logic          op_vld_i, op_rdy_o;
    logic [31:0]   op1_i, op2_i, op3_i;
    logic [8:0]    alu_opmode_o;
    logic [2:0]    alu_sew_o;
    logic [31:0]   alu_op1_o, alu_op2_o, alu_op3_o;
    logic          alu_vld_o, alu_vld_i;
    logic [31:0]   alu_result_i;
    logic          res_vld_o, res_rdy_i, res_last_o, busy_o;
    logic [31:0]   res_data_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    v_alu_seq #(.ALU_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn),
        .instr_vld_i(instr_vld_i), .instr_rdy_o(instr_rdy_o),
        .instr_opmode_i(instr_opmode_i), .instr_sew_i(instr_sew_i), .instr_vl_i(instr_vl_i),
        .op_vld_i(op_vld_i), .op_rdy_o(op_rdy_o),
        .op1_i(op1_i), .op2_i(op2_i), .op3_i(op3_i),
        .alu_opmode_o(alu_opmode_o), .alu_sew_o(alu_sew_o),
        .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_op3_o(alu_op3_o),
        .alu_vld_o(alu_vld_o), .alu_vld_i(alu_vld_i), .alu_result_i(alu_result_i),
        .res_vld_o(res_vld_o), .res_rdy_i(res_rdy_i),
        .res_data_o(res_data_o), .res_last_o(res_last_o), .busy_o(busy_o)
    );

    function automatic logic [31:0] alu_fn(input logic [8:0] op, input logic [2:0] sew,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        logic [31:0] r;
        case (op)
            OPM_ADD: r = a + b;
            OPM_SUB: r = a - b;
            OPM_MAC: r = a * b + c;
            default: r = a ^ b ^ c;
        endcase
        return r ^ {29'd0, sew};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fixed-latency, non-stallable ALU sharing rstn with the sequencer.
    logic [LAT-1:0] vpipe;
    logic [31:0]    dpipe [LAT];
    always @(posedge clk) begin
        if (!rstn) begin
            vpipe <= '0;
        end else begin
            vpipe    <= {vpipe[LAT-2:0], alu_vld_o};
            dpipe[0] <= alu_fn(alu_opmode_o, alu_sew_o, alu_op1_o, alu_op2_o, alu_op3_o);
            for (int i = LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
        end
    end
    assign alu_vld_i    = vpipe[LAT-1];
    assign alu_result_i = dpipe[LAT-1];

    // Scoreboard: expected {last,data} pushed at issue, compared at each result handshake.
    logic [32:0] sb_q [$];
    logic [8:0]  exp_op;
    logic [2:0]  exp_sew;
    logic [7:0]  exp_vl;
    int          iss_idx = 0, pop_idx = 0, outst = 0, last_pop_cyc = -1;
    logic [2:0]  prev_sew;
    logic        prev_busy;

    always @(negedge clk) begin
        if (!rstn) begin
            sb_q.delete();
            iss_idx   = 0;
            pop_idx   = 0;
            outst     = 0;
            prev_sew  = alu_sew_o;
            prev_busy = 1'b0;
        end else begin
            if (busy_o) begin
                chk("opmode_hold", alu_opmode_o, exp_op);
                chk("sew_hold", alu_sew_o, exp_sew);
            end
            if (alu_sew_o !== prev_sew) chk("sew_change_in_idle", prev_busy, 1'b0);
            if (alu_vld_i) chk("spurious_ret", outst > 0, 1'b1);
            if (alu_vld_o) begin
                chk("op_pass", {alu_op1_o, alu_op2_o, alu_op3_o}, {op1_i, op2_i, op3_i});
                chk("credit", outst + 1 <= int'(DEPTH), 1'b1);
                sb_q.push_back({iss_idx == int'(exp_vl) - 1,
                                alu_fn(exp_op, exp_sew, op1_i, op2_i, op3_i)});
                iss_idx++;
                outst++;
            end
            if (res_vld_o && res_rdy_i) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1'b1, 1'b0);
                end else begin
                    logic [32:0] e;
                    e = sb_q.pop_front();
                    chk("res_data", res_data_o, e[31:0]);
                    chk("res_last", res_last_o, e[32]);
                end
                pop_idx++;
                outst--;
                last_pop_cyc = cyc;
            end
            if (instr_vld_i && instr_rdy_o) begin
                exp_op  = instr_opmode_i;
                exp_sew = instr_sew_i;
                exp_vl  = instr_vl_i;
                iss_idx = 0;
                pop_idx = 0;
            end
            prev_sew  = alu_sew_o;
            prev_busy = busy_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        op1_i = $urandom;
        op2_i = $urandom;
        op3_i = $urandom;
    endtask

    task automatic send(input logic [8:0] op, input logic [2:0] sew, input logic [7:0] vl);
        tick();
        instr_vld_i    = 1'b1;
        instr_opmode_i = op;
        instr_sew_i    = sew;
        instr_vl_i     = vl;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("idle_timeout", ok, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_instr_rdy"}, instr_rdy_o, 1'b1);
        chk({tag, "_op_rdy"}, op_rdy_o, 1'b0);
        chk({tag, "_alu_vld"}, alu_vld_o, 1'b0);
        chk({tag, "_res_vld"}, res_vld_o, 1'b0);
        chk({tag, "_res_last"}, res_last_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_opmode"}, alu_opmode_o, 9'd0);
        chk({tag, "_sew"}, alu_sew_o, 3'd0);
    endtask

    initial begin
        int n_iss, first_iss, last_iss, first_res, busy_fall, acc_cyc;
        bit seen, ok;

        rstn = 1'b0; instr_vld_i = 1'b0; instr_opmode_i = '0; instr_sew_i = '0;
        instr_vl_i = '0; op_vld_i = 1'b0; res_rdy_i = 1'b0;
        op1_i = '0; op2_i = '0; op3_i = '0;
        tick(); tick();
        @(negedge clk);
        chk_reset_outputs("reset");
        tick();
        rstn = 1'b1;

        // 1: vl=5 full-rate stream
        send(OPM_ADD, SEW_32, 8'd5);
        op_vld_i = 1'b1; res_rdy_i = 1'b1;
        @(negedge clk);
        tick();
        instr_vld_i = 1'b0;
        n_iss = 0; first_iss = -1; last_iss = -1; first_res = -1; busy_fall = -1;
        for (int idx = 0; idx < 20; idx++) begin
            @(negedge clk);
            if (alu_vld_o) begin
                n_iss++;
                if (first_iss < 0) first_iss = idx;
                last_iss = idx;
            end
            if (res_vld_o && first_res < 0) first_res = idx;
            if (!busy_o && busy_fall < 0) busy_fall = idx;
            tick();
        end
        chk("t1_issues", n_iss, 5);
        chk("t1_first_issue", first_iss, 0);
        chk("t1_last_issue", last_iss, 4);
        chk("t1_first_res", first_res, 5);
        chk("t1_busy_fall", busy_fall, 10);
        chk("t1_pops", pop_idx, 5);

        // 2: vl=0 accepted, nothing issued
        send(OPM_SUB, SEW_8, 8'd0);
        op_vld_i = 1'b0;
        @(negedge clk);
        chk("t2_accept_rdy", instr_rdy_o, 1'b1);
        tick();
        instr_vld_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (alu_vld_o || res_vld_o || busy_o || !instr_rdy_o) seen = 1'b1;
            tick();
        end
        chk("t2_quiet", seen, 1'b0);

        // 3: back-pressure stalls issue at the credit limit
        send(OPM_SUB, SEW_16, 8'd10);
        op_vld_i = 1'b1; res_rdy_i = 1'b0;
        @(negedge clk);
        tick();
        instr_vld_i = 1'b0;
        n_iss = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (alu_vld_o) n_iss++;
            if (i == 14) begin
                chk("t3_issues_stalled", n_iss, DEPTH);
                chk("t3_op_rdy_low", op_rdy_o, 1'b0);
                chk("t3_res_pending", res_vld_o, 1'b1);
            end
            tick();
        end
        res_rdy_i = 1'b1;
        wait_idle(200);
        chk("t3_pops", pop_idx, 10);

        // 4: toggling operand valid, random result ready
        send(9'h100, SEW_16, 8'd8);
        op_vld_i = 1'b1;
        @(negedge clk);
        tick();
        instr_vld_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
            tick();
            op_vld_i  = ~op_vld_i;
            res_rdy_i = 1'($urandom_range(0, 1));
        end
        chk("t4_timeout", ok, 1'b1);
        chk("t4_pops", pop_idx, 8);

        // 5: back-to-back instructions
        send(OPM_ADD, SEW_8, 8'd3);
        op_vld_i = 1'b1; res_rdy_i = 1'b1;
        @(negedge clk);
        tick();
        instr_opmode_i = OPM_MAC; instr_sew_i = SEW_16; instr_vl_i = 8'd2;
        acc_cyc = -100;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_rdy_o) begin
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        chk("t5_accept_after_pop", acc_cyc, last_pop_cyc + 1);
        tick();
        instr_vld_i = 1'b0;
        wait_idle(100);
        chk("t5_pops", pop_idx, 2);

        // 6: reset with three elements in flight
        send(OPM_ADD, SEW_32, 8'd10);
        op_vld_i = 1'b1; res_rdy_i = 1'b0;
        @(negedge clk);
        tick();
        instr_vld_i = 1'b0;
        n_iss = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (alu_vld_o) n_iss++;
            if (n_iss == 3) break;
            tick();
        end
        chk("t6_three_issued", n_iss, 3);
        tick();
        op_vld_i = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6_rst");
        res_rdy_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            if (res_vld_o || alu_vld_o) seen = 1'b1;
        end
        chk("t6_no_residue", seen, 1'b0);
        send(OPM_SUB, SEW_8, 8'd2);
        op_vld_i = 1'b1;
        @(negedge clk);
        tick();
        instr_vld_i = 1'b0;
        wait_idle(100);
        chk("t6_pops", pop_idx, 2);
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
